// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory responder: func3 encodings, FSM states,
// the LSQ entry layout and the load-result formatter.
package dmem_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

    // LSQ entry, shared by load and store paths; each path uses a subset.
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  func3;
        logic [4:0]  rob_tag;
        logic [6:0]  pd;
        logic [31:0] ps2_data;
        logic        sw_sh_signal; // 1 = sh, 0 = sw
    } lsq_t;

    // Select and extend the addressed byte/half of a RAM word.
    function automatic logic [31:0] format_load(input logic [31:0] word,
                                                input logic [2:0]  func3,
                                                input logic [1:0]  lane);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        unique case (lane)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (func3)
            F3_LB:   format_load = {{24{byte_v[7]}}, byte_v};
            F3_LH:   format_load = {{16{half_v[15]}}, half_v};
            F3_LW:   format_load = word;
            F3_LBU:  format_load = {24'h0, byte_v};
            F3_LHU:  format_load = {16'h0, half_v};
            default: format_load = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_array.sv
// Word RAM with per-byte write enables and a combinational read port.
module dmem_array #(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned IdxW = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [3:0]      be_i,
    input  logic [IdxW-1:0] waddr_i,
    input  logic [31:0]     wdata_i,
    input  logic [IdxW-1:0] raddr_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Byte-enabled write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: commits retired stores and serves one load at a
// time with a fixed latency, returning formatted data tagged for the ROB.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_mem,
    input  lsq_t        data_load,
    input  logic        store_wb,
    input  lsq_t        data_out,
    input  logic        mispredict,
    output logic        load_ready,
    output logic        mem_valid,
    output logic [4:0]  mem_rob_tag,
    output logic [6:0]  mem_pd,
    output logic [31:0] mem_data
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    // Counter value on entering BUSY; BUSY lasts LOAD_LAT-1 cycles.
    localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

    dmem_state_t      state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             accept;
    logic             resp_fire;
    logic [IDX_W+1:0] ld_addr_q;
    logic [2:0]       ld_func3_q;
    logic [4:0]       ld_tag_q;
    logic [6:0]       ld_pd_q;
    logic             mem_valid_q;
    logic [4:0]       mem_rob_tag_q;
    logic [6:0]       mem_pd_q;
    logic [31:0]      mem_data_q;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      rd_word;

    // Store byte enables and lane-replicated write data.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = data_out.ps2_data;
        if (data_out.sw_sh_signal) begin
            st_be    = data_out.addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {data_out.ps2_data[15:0], data_out.ps2_data[15:0]};
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (store_wb),
        .be_i    (st_be),
        .waddr_i (data_out.addr[IDX_W+1:2]),
        .wdata_i (st_wdata),
        .raddr_i (ld_addr_q[IDX_W+1:2]),
        .rdata_o (rd_word)
    );

    // Next-state logic for the load FSM and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_mem && !mispredict) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (LOAD_LAT == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (mispredict) begin
                    state_d = IDLE;
                end else if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp_fire  = (state_q == RESP) && !mispredict;
    assign load_ready = (state_q == IDLE);

    // FSM, counter and latched load request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            ld_addr_q  <= '0;
            ld_func3_q <= 3'd0;
            ld_tag_q   <= 5'd0;
            ld_pd_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ld_addr_q  <= data_load.addr[IDX_W+1:0];
                ld_func3_q <= data_load.func3;
                ld_tag_q   <= data_load.rob_tag;
                ld_pd_q    <= data_load.pd;
            end
        end
    end

    // Registered response; data fields hold their last value between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q   <= 1'b0;
            mem_rob_tag_q <= 5'd0;
            mem_pd_q      <= 7'd0;
            mem_data_q    <= 32'd0;
        end else begin
            mem_valid_q <= resp_fire;
            if (resp_fire) begin
                mem_rob_tag_q <= ld_tag_q;
                mem_pd_q      <= ld_pd_q;
                mem_data_q    <= format_load(rd_word, ld_func3_q, ld_addr_q[1:0]);
            end
        end
    end

    assign mem_valid   = mem_valid_q;
    assign mem_rob_tag = mem_rob_tag_q;
    assign mem_pd      = mem_pd_q;
    assign mem_data    = mem_data_q;

    logic unused_lsq;
    assign unused_lsq = ^{data_load.ps2_data, data_load.sw_sh_signal,
                          data_load.addr[31:IDX_W+2], data_out.func3, data_out.rob_tag,
                          data_out.pd, data_out.addr[31:IDX_W+2], data_out.addr[0]};

`ifndef SYNTHESIS
    // Requests presented while busy are dropped; flag them in simulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(load_mem && !load_ready))
            else $warning("dmem_ctrl: load_mem ignored while busy");
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with hand-computed expected values.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_mem;
    lsq_t        data_load;
    logic        store_wb;
    lsq_t        data_out;
    logic        mispredict;
    logic        load_ready;
    logic        mem_valid;
    logic [4:0]  mem_rob_tag;
    logic [6:0]  mem_pd;
    logic [31:0] mem_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_mem    (load_mem),
        .data_load   (data_load),
        .store_wb    (store_wb),
        .data_out    (data_out),
        .mispredict  (mispredict),
        .load_ready  (load_ready),
        .mem_valid   (mem_valid),
        .mem_rob_tag (mem_rob_tag),
        .mem_pd      (mem_pd),
        .mem_data    (mem_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [2:0] f3,
                            input logic [4:0] tag, input logic [6:0] pd);
        data_load         = '0;
        data_load.addr    = addr;
        data_load.func3   = f3;
        data_load.rob_tag = tag;
        data_load.pd      = pd;
        load_mem          = 1'b1;
    endtask

    task automatic set_store(input logic [31:0] addr, input logic [31:0] data, input logic sh);
        data_out              = '0;
        data_out.addr         = addr;
        data_out.ps2_data     = data;
        data_out.sw_sh_signal = sh;
        store_wb              = 1'b1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic sh);
        set_store(addr, data, sh);
        step();
        store_wb = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic [4:0] rob, input logic [6:0] pd,
                            input logic [31:0] exp);
        chk({tag, ".valid"}, {31'd0, mem_valid}, 32'd1);
        chk({tag, ".data"}, mem_data, exp);
        chk({tag, ".rob"}, {27'd0, mem_rob_tag}, {27'd0, rob});
        chk({tag, ".pd"}, {25'd0, mem_pd}, {25'd0, pd});
        chk({tag, ".ready"}, {31'd0, load_ready}, 32'd1);
    endtask

    // Full load transaction: accept, LAT quiet edges, one-cycle response.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rob, input logic [6:0] pd, input logic [31:0] exp);
        chk({tag, ".rdy"}, {31'd0, load_ready}, 32'd1);
        set_load(addr, f3, rob, pd);
        step();
        load_mem = 1'b0;
        for (int i = 0; i < int'(LAT); i++) begin
            chk({tag, ".early"}, {31'd0, mem_valid}, 32'd0);
            step();
        end
        chk_resp(tag, rob, pd, exp);
        step();
        chk({tag, ".pulse"}, {31'd0, mem_valid}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        load_mem   = 1'b0;
        store_wb   = 1'b0;
        mispredict = 1'b0;
        data_load  = '0;
        data_out   = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst.ready", {31'd0, load_ready}, 32'd1);
        chk("rst.valid", {31'd0, mem_valid}, 32'd0);
        chk("rst.rob", {27'd0, mem_rob_tag}, 32'd0);
        chk("rst.pd", {25'd0, mem_pd}, 32'd0);
        chk("rst.data", mem_data, 32'd0);

        // T1
        do_store(32'h10, 32'hDEADBEEF, 1'b0);
        do_load("t1.lw", 32'h10, F3_LW, 5'd3, 7'd9, 32'hDEADBEEF);

        // T2
        do_store(32'h12, 32'h00001234, 1'b1);
        do_load("t2.lhu", 32'h12, F3_LHU, 5'd1, 7'd2, 32'h00001234);
        do_load("t2.lw", 32'h10, F3_LW, 5'd2, 7'd3, 32'h1234BEEF);

        // T3
        do_store(32'h10, 32'h80FF7F01, 1'b0);
        do_load("t3.lb13", 32'h13, F3_LB, 5'd4, 7'd5, 32'hFFFFFF80);
        do_load("t3.lbu13", 32'h13, F3_LBU, 5'd5, 7'd6, 32'h00000080);
        do_load("t3.lb10", 32'h10, F3_LB, 5'd6, 7'd7, 32'h00000001);
        do_load("t3.lh10", 32'h10, F3_LH, 5'd7, 7'd8, 32'h00007F01);
        do_load("t3.lh12", 32'h12, F3_LH, 5'd8, 7'd9, 32'hFFFF80FF);
        do_load("t3.f3bad", 32'h10, 3'b011, 5'd9, 7'd10, 32'h00000000);

        // T4: flush while BUSY
        set_load(32'h10, F3_LW, 5'd10, 7'd20);
        step();
        load_mem   = 1'b0;
        mispredict = 1'b1;
        step();
        mispredict = 1'b0;
        chk("t4.ready", {31'd0, load_ready}, 32'd1);
        chk("t4.novalid0", {31'd0, mem_valid}, 32'd0);
        step();
        chk("t4.novalid1", {31'd0, mem_valid}, 32'd0);
        step();
        chk("t4.novalid2", {31'd0, mem_valid}, 32'd0);
        do_load("t4.after", 32'h10, F3_LW, 5'd11, 7'd21, 32'h80FF7F01);

        // T5: request while BUSY ignored; back-to-back on the response cycle
        set_load(32'h10, F3_LBU, 5'd12, 7'd22);
        step();
        set_load(32'h12, F3_LW, 5'd31, 7'd99);
        chk("t5.busy", {31'd0, load_ready}, 32'd0);
        step();
        load_mem = 1'b0;
        chk("t5.resp.early", {31'd0, mem_valid}, 32'd0);
        step();
        chk_resp("t5.a", 5'd12, 7'd22, 32'h00000001);
        set_load(32'h13, F3_LB, 5'd13, 7'd23);
        step();
        load_mem = 1'b0;
        chk("t5.noextra0", {31'd0, mem_valid}, 32'd0);
        step();
        chk("t5.noextra1", {31'd0, mem_valid}, 32'd0);
        step();
        chk_resp("t5.b", 5'd13, 7'd23, 32'hFFFFFF80);
        step();
        chk("t5.pulse", {31'd0, mem_valid}, 32'd0);

        // T6: store during BUSY is visible; address aliasing
        set_load(32'h20, F3_LW, 5'd14, 7'd24);
        step();
        load_mem = 1'b0;
        set_store(32'h20, 32'hCAFEF00D, 1'b0);
        step();
        store_wb = 1'b0;
        chk("t6.early", {31'd0, mem_valid}, 32'd0);
        step();
        chk_resp("t6.busy_st", 5'd14, 7'd24, 32'hCAFEF00D);
        do_load("t6.alias", 32'd4 * DEPTH + 32'h20, F3_LW, 5'd15, 7'd25, 32'hCAFEF00D);

        // Store in the RESP cycle: load sees the old word
        do_store(32'h24, 32'h11111111, 1'b0);
        set_load(32'h24, F3_LW, 5'd16, 7'd26);
        step();
        load_mem = 1'b0;
        step();
        set_store(32'h24, 32'h22222222, 1'b0);
        step();
        store_wb = 1'b0;
        chk_resp("resp_st.old", 5'd16, 7'd26, 32'h11111111);
        do_load("resp_st.new", 32'h24, F3_LW, 5'd17, 7'd27, 32'h22222222);

        // Load and store together in IDLE: both accepted
        set_load(32'h24, F3_LHU, 5'd18, 7'd28);
        set_store(32'h28, 32'h0000ABCD, 1'b1);
        step();
        load_mem = 1'b0;
        store_wb = 1'b0;
        step();
        step();
        chk_resp("both.ld", 5'd18, 7'd28, 32'h00002222);
        do_load("both.st", 32'h28, F3_LHU, 5'd19, 7'd29, 32'h0000ABCD);

        // Flush in IDLE blocks accept
        set_load(32'h10, F3_LW, 5'd20, 7'd30);
        mispredict = 1'b1;
        step();
        load_mem   = 1'b0;
        mispredict = 1'b0;
        chk("idle_flush.ready", {31'd0, load_ready}, 32'd1);
        step();
        chk("idle_flush.nv0", {31'd0, mem_valid}, 32'd0);
        step();
        chk("idle_flush.nv1", {31'd0, mem_valid}, 32'd0);

        // Flush in RESP suppresses the response
        set_load(32'h10, F3_LW, 5'd21, 7'd31);
        step();
        load_mem = 1'b0;
        step();
        mispredict = 1'b1;
        step();
        mispredict = 1'b0;
        chk("resp_flush.nv", {31'd0, mem_valid}, 32'd0);
        chk("resp_flush.ready", {31'd0, load_ready}, 32'd1);

        // Reset mid-load drops the response; RAM is retained
        set_load(32'h10, F3_LW, 5'd22, 7'd32);
        step();
        load_mem = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst.ready", {31'd0, load_ready}, 32'd1);
        chk("mid_rst.nv", {31'd0, mem_valid}, 32'd0);
        chk("mid_rst.data", mem_data, 32'd0);
        step();
        chk("mid_rst.nv1", {31'd0, mem_valid}, 32'd0);
        do_load("mid_rst.ram", 32'h10, F3_LW, 5'd23, 7'd33, 32'h80FF7F01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
